id_ex_stage: RTL and testbench

- Decode and ID/EX pipeline register that drives the execute-stage ALU (4-bit opcode, op1, op2) in the 5-stage RISC-V RV32I core.
- Decodes a fetched instruction, generates its immediate and registers control, operands and PC into EX.
- Resolves operand forwarding from EX/MEM and MEM/WB on its output side.
- Flags load-use hazards to the fetch/decode stall logic.

---
 rtl/id_ex_stage.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_id_ex_stage.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// RV32I decode and ID/EX pipeline register with output-side operand forwarding and load-use detection.
// Build option: define ID_EX_FORWARD_EN to enable EX/MEM and MEM/WB forwarding.
module id_ex_stage #(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            in_valid,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [4:0]      exmem_rd,
    input  logic            exmem_regwrite,
    input  logic [XLEN-1:0] exmem_result,
    input  logic [4:0]      memwb_rd,
    input  logic            memwb_regwrite,
    input  logic [XLEN-1:0] memwb_result,
    output logic [3:0]      alu_opcode,
    output logic [XLEN-1:0] alu_op1,
    output logic [XLEN-1:0] alu_op2,
    output logic [XLEN-1:0] ex_store_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [XLEN-1:0] ex_pc,
    output logic [2:0]      ex_funct3,
    output logic [4:0]      ex_rd,
    output logic            ex_valid,
    output logic            ex_regwrite,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_branch,
    output logic            ex_jump,
    output logic            ex_jalr,
    output logic            ex_illegal,
    output logic            load_use_hazard
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    localparam logic [1:0] SRC1_REG  = 2'd0;
    localparam logic [1:0] SRC1_PC   = 2'd1;
    localparam logic [1:0] SRC1_ZERO = 2'd2;
    localparam logic [1:0] SRC2_REG  = 2'd0;
    localparam logic [1:0] SRC2_IMM  = 2'd1;
    localparam logic [1:0] SRC2_FOUR = 2'd2;

    function automatic logic [3:0] alu_map(input logic [2:0] f3, input logic alt, input logic is_r);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (is_r && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    logic [6:0]      major;
    logic [2:0]      funct3;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign major  = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign rd     = in_instr[11:7];
    assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u  = {in_instr[31:12], 12'b0};
    assign imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    logic [3:0]      opcode_next;
    logic [1:0]      src1_next, src2_next;
    logic [XLEN-1:0] imm_next;
    logic            regwrite_next, mem_read_next, mem_write_next;
    logic            branch_next, jump_next, jalr_next, illegal_next;

    // An invalid slot decodes to all-zero control, so a bubble is just the default path.
    always_comb begin
        opcode_next    = ALU_ADD;
        src1_next      = SRC1_REG;
        src2_next      = SRC2_REG;
        imm_next       = '0;
        regwrite_next  = 1'b0;
        mem_read_next  = 1'b0;
        mem_write_next = 1'b0;
        branch_next    = 1'b0;
        jump_next      = 1'b0;
        jalr_next      = 1'b0;
        illegal_next   = 1'b0;
        if (in_valid) begin
            case (major)
                OP_R: begin
                    opcode_next   = alu_map(funct3, in_instr[30], 1'b1);
                    regwrite_next = 1'b1;
                end
                OP_IMM: begin
                    opcode_next   = alu_map(funct3, in_instr[30], 1'b0);
                    src2_next     = SRC2_IMM;
                    imm_next      = imm_i;
                    regwrite_next = 1'b1;
                end
                OP_LOAD: begin
                    src2_next     = SRC2_IMM;
                    imm_next      = imm_i;
                    regwrite_next = 1'b1;
                    mem_read_next = 1'b1;
                end
                OP_STORE: begin
                    src2_next      = SRC2_IMM;
                    imm_next       = imm_s;
                    mem_write_next = 1'b1;
                end
                OP_BRANCH: begin
                    case (funct3[2:1])
                        2'b10:   opcode_next = ALU_SLT;
                        2'b11:   opcode_next = ALU_SLTU;
                        default: opcode_next = ALU_SUB;
                    endcase
                    imm_next    = imm_b;
                    branch_next = 1'b1;
                end
                OP_LUI: begin
                    src1_next     = SRC1_ZERO;
                    src2_next     = SRC2_IMM;
                    imm_next      = imm_u;
                    regwrite_next = 1'b1;
                end
                OP_AUIPC: begin
                    src1_next     = SRC1_PC;
                    src2_next     = SRC2_IMM;
                    imm_next      = imm_u;
                    regwrite_next = 1'b1;
                end
                OP_JAL: begin
                    src1_next     = SRC1_PC;
                    src2_next     = SRC2_FOUR;
                    imm_next      = imm_j;
                    regwrite_next = 1'b1;
                    jump_next     = 1'b1;
                end
                OP_JALR: begin
                    src1_next     = SRC1_PC;
                    src2_next     = SRC2_FOUR;
                    imm_next      = imm_i;
                    regwrite_next = 1'b1;
                    jump_next     = 1'b1;
                    jalr_next     = 1'b1;
                end
                default: illegal_next = 1'b1;
            endcase
            if (rd == 5'd0) regwrite_next = 1'b0;
        end
    end

    logic [3:0]      opcode_reg;
    logic [1:0]      src1_reg, src2_reg;
    logic [XLEN-1:0] imm_reg, pc_reg;
    logic [2:0]      funct3_reg;
    logic [4:0]      rd_reg;
    logic            valid_reg, regwrite_reg, mem_read_reg, mem_write_reg;
    logic            branch_reg, jump_reg, jalr_reg, illegal_reg;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            opcode_reg    <= ALU_ADD;
            src1_reg      <= SRC1_REG;
            src2_reg      <= SRC2_REG;
            imm_reg       <= '0;
            pc_reg        <= RESET_PC;
            funct3_reg    <= '0;
            rd_reg        <= '0;
            valid_reg     <= 1'b0;
            regwrite_reg  <= 1'b0;
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
            branch_reg    <= 1'b0;
            jump_reg      <= 1'b0;
            jalr_reg      <= 1'b0;
            illegal_reg   <= 1'b0;
        end else if (!stall) begin
            opcode_reg    <= opcode_next;
            src1_reg      <= src1_next;
            src2_reg      <= src2_next;
            imm_reg       <= imm_next;
            pc_reg        <= in_pc;
            funct3_reg    <= in_valid ? funct3 : 3'b000;
            rd_reg        <= in_valid ? rd : 5'd0;
            valid_reg     <= in_valid;
            regwrite_reg  <= regwrite_next;
            mem_read_reg  <= mem_read_next;
            mem_write_reg <= mem_write_next;
            branch_reg    <= branch_next;
            jump_reg      <= jump_next;
            jalr_reg      <= jalr_next;
            illegal_reg   <= illegal_next;
        end
    end

    // Per-source operand register plus its forwarding mux (gi=0: rs1, gi=1: rs2).
    logic [1:0][XLEN-1:0] fwd_data;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            localparam int IDX_LSB = 15 + 5 * gi;
            logic [4:0]      idx_reg;
            logic [XLEN-1:0] data_reg;
            logic [XLEN-1:0] rf_data;

            assign rf_data = (gi == 0) ? in_rs1_data : in_rs2_data;

            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    idx_reg  <= '0;
                    data_reg <= '0;
                end else if (!stall) begin
                    idx_reg  <= in_valid ? in_instr[IDX_LSB +: 5] : 5'd0;
                    data_reg <= in_valid ? rf_data : '0;
                end
            end

`ifdef ID_EX_FORWARD_EN
            logic [XLEN-1:0] sel_data;
            always_comb begin
                sel_data = data_reg;
                if (exmem_regwrite && exmem_rd != 5'd0 && exmem_rd == idx_reg)
                    sel_data = exmem_result;
                else if (memwb_regwrite && memwb_rd != 5'd0 && memwb_rd == idx_reg)
                    sel_data = memwb_result;
            end
            assign fwd_data[gi] = sel_data;
`else
            logic unused_idx;
            assign unused_idx   = ^idx_reg;
            assign fwd_data[gi] = data_reg;
`endif
        end
    endgenerate

`ifndef ID_EX_FORWARD_EN
    logic unused_fwd_ports;
    assign unused_fwd_ports = ^{exmem_rd, exmem_regwrite, exmem_result,
                                memwb_rd, memwb_regwrite, memwb_result};
`endif

    always_comb begin
        case (src1_reg)
            SRC1_PC:   alu_op1 = pc_reg;
            SRC1_ZERO: alu_op1 = '0;
            default:   alu_op1 = fwd_data[0];
        endcase
        case (src2_reg)
            SRC2_IMM:  alu_op2 = imm_reg;
            SRC2_FOUR: alu_op2 = XLEN'(4);
            default:   alu_op2 = fwd_data[1];
        endcase
    end

    logic src_match;
    assign src_match = (rd_reg == in_instr[19:15]) || (rd_reg == in_instr[24:20]);

    // Without forwarding every in-flight writer of a source register must be waited out.
`ifdef ID_EX_FORWARD_EN
    assign load_use_hazard = valid_reg && mem_read_reg && (rd_reg != 5'd0) && in_valid && src_match;
`else
    assign load_use_hazard = valid_reg && (mem_read_reg || regwrite_reg) && (rd_reg != 5'd0)
                             && in_valid && src_match;
`endif

    assign alu_opcode    = opcode_reg;
    assign ex_store_data = fwd_data[1];
    assign ex_imm        = imm_reg;
    assign ex_pc         = pc_reg;
    assign ex_funct3     = funct3_reg;
    assign ex_rd         = rd_reg;
    assign ex_valid      = valid_reg;
    assign ex_regwrite   = regwrite_reg;
    assign ex_mem_read   = mem_read_reg;
    assign ex_mem_write  = mem_write_reg;
    assign ex_branch     = branch_reg;
    assign ex_jump       = jump_reg;
    assign ex_jalr       = jalr_reg;
    assign ex_illegal    = illegal_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; expectations are hand-decoded RV32I vectors.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, in_valid;
    logic [31:0] in_instr, in_pc, in_rs1_data, in_rs2_data;
    logic [4:0]  exmem_rd, memwb_rd;
    logic        exmem_regwrite, memwb_regwrite;
    logic [31:0] exmem_result, memwb_result;
    logic [3:0]  alu_opcode;
    logic [31:0] alu_op1, alu_op2, ex_store_data, ex_imm, ex_pc;
    logic [2:0]  ex_funct3;
    logic [4:0]  ex_rd;
    logic        ex_valid, ex_regwrite, ex_mem_read, ex_mem_write;
    logic        ex_branch, ex_jump, ex_jalr, ex_illegal, load_use_hazard;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite), .exmem_result(exmem_result),
        .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite), .memwb_result(memwb_result),
        .alu_opcode(alu_opcode), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .ex_store_data(ex_store_data), .ex_imm(ex_imm), .ex_pc(ex_pc),
        .ex_funct3(ex_funct3), .ex_rd(ex_rd), .ex_valid(ex_valid),
        .ex_regwrite(ex_regwrite), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_jalr(ex_jalr),
        .ex_illegal(ex_illegal), .load_use_hazard(load_use_hazard)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2);
        in_valid    = 1'b1;
        in_instr    = instr;
        in_pc       = pc;
        in_rs1_data = r1;
        in_rs2_data = r2;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(32'h40B50533, 32'h0000_0100, 32'd10, 32'd3);
        exmem_rd = 5'd0; exmem_regwrite = 1'b0; exmem_result = 32'h0;
        memwb_rd = 5'd0; memwb_regwrite = 1'b0; memwb_result = 32'h0;

        // Reset held two cycles while a real instruction is presented
        step(); step();
        check("rst_valid",    32'(ex_valid), 32'd0);
        check("rst_regwrite", 32'(ex_regwrite), 32'd0);
        check("rst_opcode",   32'(alu_opcode), 32'd0);
        check("rst_pc",       ex_pc, 32'h0);
        rst = 1'b0;

        // sub a0,a0,a1
        step();
        check("sub_opcode",   32'(alu_opcode), 32'd1);
        check("sub_op1",      alu_op1, 32'd10);
        check("sub_op2",      alu_op2, 32'd3);
        check("sub_rd",       32'(ex_rd), 32'd10);
        check("sub_regwrite", 32'(ex_regwrite), 32'd1);
        check("sub_valid",    32'(ex_valid), 32'd1);
        check("sub_pc",       ex_pc, 32'h0000_0100);

        // addi x1,x0,-1
        drive(32'hFFF00093, 32'h0000_0104, 32'd0, 32'h1234);
        step();
        check("addi_opcode", 32'(alu_opcode), 32'd0);
        check("addi_op2",    alu_op2, 32'hFFFF_FFFF);
        check("addi_imm",    ex_imm, 32'hFFFF_FFFF);

        // srai x1,x1,2
        drive(32'h4020D093, 32'h0000_0108, 32'hFFFF_FFFF, 32'h0);
        step();
        check("srai_opcode",  32'(alu_opcode), 32'd9);
        check("srai_shamt",   32'(alu_op2[4:0]), 32'd2);
        check("srai_funct3",  32'(ex_funct3), 32'd5);

        // lui x5,0x12345 : op1 forced to zero
        drive(32'h123452B7, 32'h0000_010C, 32'h0000_DEAD, 32'h0);
        step();
        check("lui_op1", alu_op1, 32'h0);
        check("lui_op2", alu_op2, 32'h1234_5000);

        // jal x1,+8
        drive(32'h008000EF, 32'h0000_0110, 32'h0, 32'h0);
        step();
        check("jal_jump", 32'(ex_jump), 32'd1);
        check("jal_op1",  alu_op1, 32'h0000_0110);
        check("jal_op2",  alu_op2, 32'd4);
        check("jal_imm",  ex_imm, 32'd8);

        // bne x1,x2,+16
        drive(32'h00209863, 32'h0000_0114, 32'd7, 32'd9);
        step();
        check("bne_opcode",   32'(alu_opcode), 32'd1);
        check("bne_branch",   32'(ex_branch), 32'd1);
        check("bne_regwrite", 32'(ex_regwrite), 32'd0);
        check("bne_imm",      ex_imm, 32'd16);
        check("bne_op2",      alu_op2, 32'd9);

        // sw x2,-4(x1)
        drive(32'hFE20AE23, 32'h0000_0118, 32'h100, 32'hCAFE);
        step();
        check("sw_memwrite", 32'(ex_mem_write), 32'd1);
        check("sw_regwrite", 32'(ex_regwrite), 32'd0);
        check("sw_op2",      alu_op2, 32'hFFFF_FFFC);
        check("sw_data",     ex_store_data, 32'hCAFE);

        // addi x0,x0,1 : writes to x0 are suppressed
        drive(32'h00100013, 32'h0000_011C, 32'h0, 32'h0);
        step();
        check("x0_regwrite", 32'(ex_regwrite), 32'd0);

        // add x7,x5,x1 then sweep the forwarding inputs without clocking
        drive(32'h001283B3, 32'h0000_0120, 32'h55, 32'h11);
        step();
        exmem_rd = 5'd5; exmem_result = 32'hAA; exmem_regwrite = 1'b1;
        memwb_rd = 5'd5; memwb_result = 32'hBB; memwb_regwrite = 1'b1;
        #1;
`ifdef ID_EX_FORWARD_EN
        check("fwd_both", alu_op1, 32'hAA);
`else
        check("fwd_both", alu_op1, 32'h55);
`endif
        exmem_regwrite = 1'b0;
        #1;
`ifdef ID_EX_FORWARD_EN
        check("fwd_memwb", alu_op1, 32'hBB);
`else
        check("fwd_memwb", alu_op1, 32'h55);
`endif
        exmem_regwrite = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0;
        #1;
        check("fwd_rd0", alu_op1, 32'h55);
        memwb_rd = 5'd1;
        #1;
`ifdef ID_EX_FORWARD_EN
        check("fwd_rs2_store", ex_store_data, 32'hBB);
`else
        check("fwd_rs2_store", ex_store_data, 32'h11);
`endif
        exmem_regwrite = 1'b0; memwb_regwrite = 1'b0;
        memwb_rd = 5'd0;

        // lw x6,0(x1) in EX, then probe dependent / independent successors
        drive(32'h0000A303, 32'h0000_0124, 32'h200, 32'h0);
        step();
        check("lw_memread", 32'(ex_mem_read), 32'd1);
        in_instr = 32'h001303B3;
        #1;
        check("lu_dep", 32'(load_use_hazard), 32'd1);
        in_instr = 32'h001103B3;
        #1;
        check("lu_indep", 32'(load_use_hazard), 32'd0);

        // add x7,x2,x1 in EX, successor reads x7
        step();
        in_instr = 32'h00138433;
        #1;
`ifdef ID_EX_FORWARD_EN
        check("alu_dep_hazard", 32'(load_use_hazard), 32'd0);
`else
        check("alu_dep_hazard", 32'(load_use_hazard), 32'd1);
`endif

        // Stall holds EX for three cycles while inputs change
        drive(32'h40B50533, 32'h0000_0200, 32'd20, 32'd6);
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(32'hFFF00093 + 32'(i), 32'h0000_0300 + 32'(i * 4), 32'(i), 32'(i));
            step();
            check($sformatf("stall%0d_opcode", i), 32'(alu_opcode), 32'd1);
            check($sformatf("stall%0d_pc", i), ex_pc, 32'h0000_0200);
        end
        flush = 1'b1;
        step();
        check("flush_valid",    32'(ex_valid), 32'd0);
        check("flush_regwrite", 32'(ex_regwrite), 32'd0);
        stall = 1'b0; flush = 1'b0;

        // Illegal major opcode
        drive(32'h0000007F, 32'h0000_0400, 32'h0, 32'h0);
        step();
        check("ill_flag",     32'(ex_illegal), 32'd1);
        check("ill_regwrite", 32'(ex_regwrite), 32'd0);
        check("ill_valid",    32'(ex_valid), 32'd1);

        // in_valid=0 captures a bubble
        drive(32'h40B50533, 32'h0000_0404, 32'd1, 32'd1);
        in_valid = 1'b0;
        step();
        check("bub_valid",    32'(ex_valid), 32'd0);
        check("bub_regwrite", 32'(ex_regwrite), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
